// File: rtl/vga_timing_pkg.sv
// Shared constants for the raster timing generator: standard VGA mode,
// a tiny test mode, and sync polarity encodings.
package vga_timing_pkg;

   localparam bit POL_LOW  = 1'b0;
   localparam bit POL_HIGH = 1'b1;

   // VGA 640x480@60, 25 MHz pixel rate from a 100 MHz system clock
   localparam int VGA_H_DISPLAY     = 640;
   localparam int VGA_H_FRONT_PORCH = 16;
   localparam int VGA_H_SYNC_PULSE  = 96;
   localparam int VGA_H_BACK_PORCH  = 48;
   localparam int VGA_V_DISPLAY     = 480;
   localparam int VGA_V_FRONT_PORCH = 10;
   localparam int VGA_V_SYNC_PULSE  = 2;
   localparam int VGA_V_BACK_PORCH  = 33;
   localparam int VGA_CLK_DIV       = 4;
   localparam int VGA_CNT_W         = 10;

   // 8x4 visible mode, 16x8 total, for quick simulation
   localparam int VGA_TINY_H_DISPLAY     = 8;
   localparam int VGA_TINY_H_FRONT_PORCH = 2;
   localparam int VGA_TINY_H_SYNC_PULSE  = 3;
   localparam int VGA_TINY_H_BACK_PORCH  = 3;
   localparam int VGA_TINY_V_DISPLAY     = 4;
   localparam int VGA_TINY_V_FRONT_PORCH = 1;
   localparam int VGA_TINY_V_SYNC_PULSE  = 2;
   localparam int VGA_TINY_V_BACK_PORCH  = 1;
   localparam int VGA_TINY_CNT_W         = 4;

   // Total period of one axis from its four regions
   function automatic int axis_total(input int disp, input int fp, input int sp, input int bp);
      return disp + fp + sp + bp;
   endfunction

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: one-clock tick every CLK_DIV enabled clocks.
module clk_en_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;

   // Phase counter; holds its phase while disabled so ticking resumes in step
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         div_cnt <= '0;
      else if (enable)
         div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
   end

   // Masked by reset so the tick reads 0 during reset even with CLK_DIV = 1
   assign tick = enable && !reset && (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator. Position counters advance on the
// pixel tick; all outputs come from one registered stage loaded on that tick.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_DISPLAY     = VGA_H_DISPLAY,
   parameter int H_FRONT_PORCH = VGA_H_FRONT_PORCH,
   parameter int H_SYNC_PULSE  = VGA_H_SYNC_PULSE,
   parameter int H_BACK_PORCH  = VGA_H_BACK_PORCH,
   parameter int V_DISPLAY     = VGA_V_DISPLAY,
   parameter int V_FRONT_PORCH = VGA_V_FRONT_PORCH,
   parameter int V_SYNC_PULSE  = VGA_V_SYNC_PULSE,
   parameter int V_BACK_PORCH  = VGA_V_BACK_PORCH,
   parameter bit H_SYNC_POL    = POL_LOW,
   parameter bit V_SYNC_POL    = POL_LOW,
   parameter int CLK_DIV       = VGA_CLK_DIV,
   parameter int CNT_W         = VGA_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic             p_tick,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic             line_start,
   output logic             frame_start,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y
);

   localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH);
   localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH);

   localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_DISPLAY);
   localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_DISPLAY);
   localparam logic [CNT_W-1:0] H_SS  = CNT_W'(H_DISPLAY + H_FRONT_PORCH);
   localparam logic [CNT_W-1:0] H_SE  = CNT_W'(H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE - 1);
   localparam logic [CNT_W-1:0] V_SS  = CNT_W'(V_DISPLAY + V_FRONT_PORCH);
   localparam logic [CNT_W-1:0] V_SE  = CNT_W'(V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE - 1);

   logic [CNT_W-1:0] h, v;
   logic             tick;
   logic             h_sync_act, v_sync_act, visible;
   logic             line_q, frame_q;

   clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick   (tick)
   );

   assign p_tick = tick;

   // Decode of the pixel the counters currently hold
   assign h_sync_act = (h >= H_SS) && (h <= H_SE);
   assign v_sync_act = (v >= V_SS) && (v <= V_SE);
   assign visible    = (h < H_VIS) && (v < V_VIS);

   // Output stage captures the current pixel, then the counters step past it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h        <= '0;
         v        <= '0;
         x        <= '0;
         y        <= '0;
         hsync    <= ~H_SYNC_POL;
         vsync    <= ~V_SYNC_POL;
         video_on <= 1'b0;
         line_q   <= 1'b0;
         frame_q  <= 1'b0;
      end else if (tick) begin
         x        <= h;
         y        <= v;
         hsync    <= h_sync_act ? H_SYNC_POL : ~H_SYNC_POL;
         vsync    <= v_sync_act ? V_SYNC_POL : ~V_SYNC_POL;
         video_on <= visible;
         line_q   <= (h == '0);
         frame_q  <= (h == '0) && (v == '0);
         if (h == H_MAX) begin
            h <= '0;
            v <= (v == V_MAX) ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end else begin
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end
   end

   // Strobes read 0 whenever the generator is frozen
   assign line_start  = line_q & enable;
   assign frame_start = frame_q & enable;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen in tiny mode with CLK_DIV = 2; one
// instance per sync polarity, sharing clock, reset and enable.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b1;

   logic       lo_p_tick, lo_hsync, lo_vsync, lo_video_on, lo_line_start, lo_frame_start;
   logic [3:0] lo_x, lo_y;
   logic       hi_p_tick, hi_hsync, hi_vsync, hi_video_on, hi_line_start, hi_frame_start;
   logic [3:0] hi_x, hi_y;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = 0;
   int t1 = 0;

   typedef struct {
      int x;
      int y;
      bit hs_lo;
      bit vs_lo;
      bit von;
      bit ls;
      bit fs;
   } exp_t;

   exp_t sb[$];

   vga_timing_gen #(
      .H_DISPLAY(VGA_TINY_H_DISPLAY), .H_FRONT_PORCH(VGA_TINY_H_FRONT_PORCH),
      .H_SYNC_PULSE(VGA_TINY_H_SYNC_PULSE), .H_BACK_PORCH(VGA_TINY_H_BACK_PORCH),
      .V_DISPLAY(VGA_TINY_V_DISPLAY), .V_FRONT_PORCH(VGA_TINY_V_FRONT_PORCH),
      .V_SYNC_PULSE(VGA_TINY_V_SYNC_PULSE), .V_BACK_PORCH(VGA_TINY_V_BACK_PORCH),
      .H_SYNC_POL(POL_LOW), .V_SYNC_POL(POL_LOW), .CLK_DIV(2), .CNT_W(VGA_TINY_CNT_W)
   ) dut_lo (
      .clk(clk), .reset(reset), .enable(enable), .p_tick(lo_p_tick),
      .hsync(lo_hsync), .vsync(lo_vsync), .video_on(lo_video_on),
      .line_start(lo_line_start), .frame_start(lo_frame_start), .x(lo_x), .y(lo_y)
   );

   vga_timing_gen #(
      .H_DISPLAY(VGA_TINY_H_DISPLAY), .H_FRONT_PORCH(VGA_TINY_H_FRONT_PORCH),
      .H_SYNC_PULSE(VGA_TINY_H_SYNC_PULSE), .H_BACK_PORCH(VGA_TINY_H_BACK_PORCH),
      .V_DISPLAY(VGA_TINY_V_DISPLAY), .V_FRONT_PORCH(VGA_TINY_V_FRONT_PORCH),
      .V_SYNC_PULSE(VGA_TINY_V_SYNC_PULSE), .V_BACK_PORCH(VGA_TINY_V_BACK_PORCH),
      .H_SYNC_POL(POL_HIGH), .V_SYNC_POL(POL_HIGH), .CLK_DIV(2), .CNT_W(VGA_TINY_CNT_W)
   ) dut_hi (
      .clk(clk), .reset(reset), .enable(enable), .p_tick(hi_p_tick),
      .hsync(hi_hsync), .vsync(hi_vsync), .video_on(hi_video_on),
      .line_start(hi_line_start), .frame_start(hi_frame_start), .x(hi_x), .y(hi_y)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_x"}, lo_x, 0);
      chk({tag, "_y"}, lo_y, 0);
      chk({tag, "_von"}, lo_video_on, 0);
      chk({tag, "_ls"}, lo_line_start, 0);
      chk({tag, "_fs"}, lo_frame_start, 0);
      chk({tag, "_ptick"}, lo_p_tick, 0);
      chk({tag, "_hs_lo"}, lo_hsync, 1);
      chk({tag, "_vs_lo"}, lo_vsync, 1);
      chk({tag, "_hs_hi"}, hi_hsync, 0);
      chk({tag, "_vs_hi"}, hi_vsync, 0);
   endtask

   // Wait (bounded) for a pixel tick, queue what that pixel must look like,
   // then compare once the output stage has loaded it.
   task automatic step_pixel(input int ex, input int ey);
      exp_t e;
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (lo_p_tick === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         chk("tick_timeout", 0, 1);
         return;
      end
      e.x     = ex;
      e.y     = ey;
      e.hs_lo = !(ex >= 10 && ex <= 12);
      e.vs_lo = !(ey >= 5 && ey <= 6);
      e.von   = (ex < 8) && (ey < 4);
      e.ls    = (ex == 0);
      e.fs    = (ex == 0) && (ey == 0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("px_x", lo_x, e.x);
      chk("px_y", lo_y, e.y);
      chk("px_hs_lo", lo_hsync, e.hs_lo);
      chk("px_vs_lo", lo_vsync, e.vs_lo);
      chk("px_hs_hi", hi_hsync, !e.hs_lo);
      chk("px_vs_hi", hi_vsync, !e.vs_lo);
      chk("px_von", lo_video_on, e.von);
      chk("px_ls", lo_line_start, e.ls);
      chk("px_fs", lo_frame_start, e.fs);
      chk("px_hi_x", hi_x, e.x);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_reset("rst");

      // First tick two clocks after release
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("c1_von", lo_video_on, 0);
      chk("c1_ptick", lo_p_tick, 1);
      @(posedge clk); #1;
      chk("c2_x", lo_x, 0);
      chk("c2_y", lo_y, 0);
      chk("c2_von", lo_video_on, 1);
      chk("c2_fs", lo_frame_start, 1);
      chk("c2_ls", lo_line_start, 1);
      t0 = cyc;
      @(posedge clk); #1;
      chk("c3_fs_clear", lo_frame_start, 0);
      chk("c3_ls_clear", lo_line_start, 0);

      // Full frame including both wrap points, back to (0,0)
      for (int p = 1; p <= 128; p++) step_pixel(p % 16, (p / 16) % 8);
      t1 = cyc;
      chk("frame_period", t1 - t0, 256);

      // Advance to x = 6 and freeze for five clocks
      for (int p = 1; p <= 6; p++) step_pixel(p, 0);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold_ptick", lo_p_tick, 0);
         chk("hold_x", lo_x, 6);
         chk("hold_von", lo_video_on, 1);
      end
      enable = 1'b1;
      @(posedge clk); #1;
      chk("resume_x_still6", lo_x, 6);
      chk("resume_ptick", lo_p_tick, 1);
      @(posedge clk); #1;
      chk("resume_x7", lo_x, 7);

      // Run to (11,2) and hit reset mid-frame
      for (int p = 8; p <= 43; p++) step_pixel(p % 16, p / 16);
      chk("pre_rst_hs_lo", lo_hsync, 0);
      reset = 1'b1;
      #1;
      check_reset("async_rst");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step_pixel(0, 0);
      step_pixel(1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/raster timing generator, successor to the fixed 640x480 sync block. It adds an internal pixel-clock-enable divider, configurable sync polarity and counter width, a run/hold enable, and line/frame start strobes. All outputs are aligned in one registered output stage. It sits between the system clock and the pixel/text renderers, which consume `x`, `y`, `video_on` and the strobes.

## Interface
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT_PORCH`, 16: pixels after the visible region, before hsync.
- `H_SYNC_PULSE`, 96: hsync width in pixels.
- `H_BACK_PORCH`, 48: pixels after hsync.
- `V_DISPLAY`, 480: visible lines per frame.
- `V_FRONT_PORCH`, 10: lines after the visible region, before vsync.
- `V_SYNC_PULSE`, 2: vsync width in lines.
- `V_BACK_PORCH`, 33: lines after vsync.
- `H_SYNC_POL`, 0: active level of `hsync` (0 = active-low).
- `V_SYNC_POL`, 0: active level of `vsync`.
- `CLK_DIV`, 4: system clocks per pixel; must be >= 1.
- `CNT_W`, 10: width of `x`/`y`; H_TOTAL and V_TOTAL must each be <= 2^CNT_W.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: 1 = run; 0 = freeze divider, counters and outputs.
- `p_tick` out 1: pixel enable, one `clk` wide, every CLK_DIV clocks while enabled.
- `hsync` out 1: horizontal sync at H_SYNC_POL level during the sync region.
- `vsync` out 1: vertical sync at V_SYNC_POL level during the sync region.
- `video_on` out 1: 1 when the output position is inside the visible area.
- `line_start` out 1: one-`clk` strobe when the output stage loads x = 0.
- `frame_start` out 1: one-`clk` strobe when the output stage loads x = 0, y = 0.
- `x` out CNT_W: horizontal position of the current output pixel.
- `y` out CNT_W: vertical position of the current output pixel.

## Operation
- H_TOTAL = sum of the four H parameters; V_TOTAL likewise. Region order is display, front porch, sync, back porch.
- The hsync region is h in [H_DISPLAY+H_FRONT_PORCH, H_DISPLAY+H_FRONT_PORCH+H_SYNC_PULSE-1]. The vsync region is the same pattern on v.
- Divider: `div_cnt` counts 0..CLK_DIV-1 while `enable` = 1. `p_tick` = (`div_cnt` == CLK_DIV-1) && `enable`. With CLK_DIV = 1, `p_tick` = `enable`.
- Position counters advance only on `p_tick`:
  - h wraps from H_TOTAL-1 to 0.
  - v increments only when h wraps, and wraps from V_TOTAL-1 to 0.
- Output stage, on `p_tick`:
  - Loads `x`/`y` with the current h/v.
  - Loads `hsync`/`vsync`/`video_on` with the decode of that same h/v.
  - Sets `line_start` = (h == 0) and `frame_start` = (h == 0 && v == 0).
  - Then the counters advance.
- `line_start`/`frame_start` are cleared on the next `clk` edge without `p_tick`, so they are never wider than one clock.
- `enable` = 0 holds every register. `p_tick`, `line_start` and `frame_start` read 0; the other outputs keep their values.
- Arithmetic: counters are CNT_W bits and never overflow because the wrap compare happens first. Decode compares use CNT_W-bit unsigned values.

## Timing
- Reset values (asynchronous):
  - `div_cnt` = 0; h = v = 0; `x` = `y` = 0.
  - `video_on` = 0; `line_start` = `frame_start` = 0; `p_tick` = 0.
  - `hsync` = ~H_SYNC_POL and `vsync` = ~V_SYNC_POL (both inactive).
- The first `p_tick` comes CLK_DIV clocks after reset release with `enable` = 1. On that edge the outputs show (0,0), `video_on` = 1 and both strobes = 1.
- Latency: outputs describe the pixel the counters held one `p_tick` earlier. All outputs are mutually aligned with zero skew.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV clocks while enabled.
- Reset mid-frame: all registers return to reset values immediately. No partial strobe survives.
- `enable` falling between ticks: `div_cnt` holds, and ticking resumes at the same phase when `enable` rises.

## Structure
- Shared package/header `vga_timing_pkg`:
  - Standard mode constants (VGA 640x480@60: the defaults above, plus CLK_DIV = 4 for 100 MHz).
  - A small 8x4 test mode (next bullet).
  - Sync polarity constants POL_LOW = 0, POL_HIGH = 1.
- Test mode `VGA_TINY_*`: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), CNT_W 4.
- One sub-module: `clk_en_div` (parameters CLK_DIV; ports `clk`, `reset`, `enable`, `tick`), instantiated once for `p_tick`.

## Test plan
- Tiny mode, CLK_DIV = 2, `enable` = 1 from reset -> first `p_tick` at clock 2 after release. `x` = 0, `y` = 0, `video_on` = 1, `frame_start` = 1 for exactly one clock. Frame repeats every 256 clocks.
- Tiny mode, polarity low -> `hsync` = 0 exactly while `x` is 10..12 and 1 otherwise. `vsync` = 0 while `y` is 5..6. `video_on` = 0 for `x` >= 8 or `y` >= 4.
- Tiny mode, H_SYNC_POL = V_SYNC_POL = 1 -> `hsync`/`vsync` waveforms are the exact inverse of the previous test. Reset value of `hsync` is 0.
- Wrap check:
  - At `x` = 15, `y` = 3, the next `p_tick` gives `x` = 0, `y` = 4, `line_start` = 1, `frame_start` = 0.
  - At `x` = 15, `y` = 7, the next `p_tick` gives (0,0) with both strobes = 1.
- Drop `enable` for 5 clocks at `x` = 6 -> no `p_tick`; outputs hold. After re-enable, `x` = 7 appears after the remaining divider phase.
- Assert `reset` for 1 clock at `x` = 11, `y` = 2 -> all outputs return to reset values asynchronously. The next frame starts at (0,0) with `frame_start` = 1.
